// File: rtl/ex_alu_arbiter_if.sv
// Bundle of the two requester ports, their response buffers and the shared-ALU side.
// The arbiter connects through the slave modport; the environment uses the master modport.
interface ex_alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [3:0]  req0_ctrl;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [3:0]  req1_ctrl;
   logic [31:0] req1_a;
   logic [31:0] req1_b;

   logic        rsp0_valid;
   logic        rsp0_ready;
   logic [31:0] rsp0_y;
   logic        rsp1_valid;
   logic        rsp1_ready;
   logic [31:0] rsp1_y;

   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_y;

   modport slave (
      input  req0_valid, req0_ctrl, req0_a, req0_b,
      input  req1_valid, req1_ctrl, req1_a, req1_b,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_y, rsp1_valid, rsp1_y,
      input  rsp0_ready, rsp1_ready,
      output alu_ctrl, alu_a, alu_b,
      input  alu_y
   );

   modport master (
      output req0_valid, req0_ctrl, req0_a, req0_b,
      output req1_valid, req1_ctrl, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_y, rsp1_valid, rsp1_y,
      output rsp0_ready, rsp1_ready,
      input  alu_ctrl, alu_a, alu_b,
      output alu_y
   );
endinterface

// File: rtl/ex_alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU, with a one-entry result buffer per port.
// Define ALU_ARB_RR_EN for round-robin tie breaking; otherwise port 0 wins every tie.
module ex_alu_arbiter (
   input  logic            clk,
   input  logic            aresetn,
   ex_alu_arbiter_if.slave bus
);

   logic [1:0]  req_valid;
   logic [1:0]  rsp_ready;
   logic [3:0]  req_ctrl [2];
   logic [31:0] req_a    [2];
   logic [31:0] req_b    [2];

   logic [1:0]  elig;
   logic [1:0]  grant;

   logic [1:0]  rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_y_q [2];
   logic [31:0] rsp_y_d [2];
   logic        last_grant_q, last_grant_d;

   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a;
   logic [31:0] alu_b;

   assign req_valid   = {bus.req1_valid, bus.req0_valid};
   assign rsp_ready   = {bus.rsp1_ready, bus.rsp0_ready};
   assign req_ctrl[0] = bus.req0_ctrl;
   assign req_ctrl[1] = bus.req1_ctrl;
   assign req_a[0]    = bus.req0_a;
   assign req_a[1]    = bus.req1_a;
   assign req_b[0]    = bus.req0_b;
   assign req_b[1]    = bus.req1_b;

   // A full buffer only accepts when it is being drained in the same cycle.
   always_comb begin : arbitrate
      elig  = '0;
      grant = '0;
      for (int i = 0; i < 2; i++) begin
         elig[i] = aresetn & req_valid[i] & (~rsp_valid_q[i] | rsp_ready[i]);
      end
      if (elig == 2'b11) begin
`ifdef ALU_ARB_RR_EN
         grant = last_grant_q ? 2'b01 : 2'b10;
`else
         grant = 2'b01;
`endif
      end else begin
         grant = elig;
      end
   end

   always_comb begin : datapath
      alu_ctrl     = '0;
      alu_a        = '0;
      alu_b        = '0;
      last_grant_d = last_grant_q;
      if (grant[0]) begin
         alu_ctrl     = req_ctrl[0];
         alu_a        = req_a[0];
         alu_b        = req_b[0];
         last_grant_d = 1'b0;
      end else if (grant[1]) begin
         alu_ctrl     = req_ctrl[1];
         alu_a        = req_a[1];
         alu_b        = req_b[1];
         last_grant_d = 1'b1;
      end

      // A new grant overwrites the buffer even while it drains, giving 1/cycle per port.
      for (int i = 0; i < 2; i++) begin
         rsp_valid_d[i] = rsp_valid_q[i];
         rsp_y_d[i]     = rsp_y_q[i];
         if (grant[i]) begin
            rsp_valid_d[i] = 1'b1;
            rsp_y_d[i]     = bus.alu_y;
         end else if (rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rsp_valid_q  <= '0;
         last_grant_q <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            rsp_y_q[i] <= '0;
         end
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         last_grant_q <= last_grant_d;
         for (int i = 0; i < 2; i++) begin
            rsp_y_q[i] <= rsp_y_d[i];
         end
      end
   end

   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign bus.rsp0_valid = rsp_valid_q[0];
   assign bus.rsp1_valid = rsp_valid_q[1];
   assign bus.rsp0_y     = rsp_y_q[0];
   assign bus.rsp1_y     = rsp_y_q[1];
   assign bus.alu_ctrl   = alu_ctrl;
   assign bus.alu_a      = alu_a;
   assign bus.alu_b      = alu_b;

endmodule

// File: tb/tb_ex_alu_arbiter.sv
// Scoreboard bench for ex_alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level arbitration model and a behavioural shared ALU.
module tb_ex_alu_arbiter;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd7;

   logic clk = 1'b0;
   logic aresetn = 1'b0;

   ex_alu_arbiter_if bus ();

   ex_alu_arbiter dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      case (c)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    return (a < b) ? 32'd1 : 32'd0;
         4'd7:    return a << b[4:0];
         4'd8:    return a >> b[4:0];
         4'd9:    return $unsigned($signed(a) >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   // Shared ALU lives in the environment.
   assign bus.alu_y = alu_ref(bus.alu_ctrl, bus.alu_a, bus.alu_b);

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic done = 1'b0;

   // Transaction-level model: buffer occupancy, last granted port, expected results per port.
   logic m_full0 = 1'b0;
   logic m_full1 = 1'b0;
   logic m_last  = 1'b1;
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic cycle(input logic v0, input logic [3:0] c0, input logic [31:0] a0,
                        input logic [31:0] b0, input logic v1, input logic [3:0] c1,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic r0, input logic r1);
      logic e0, e1, g0, g1, tie_to0;
      logic [3:0]  ec;
      logic [31:0] ea, eb;
      @(negedge clk);
      bus.req0_valid = v0; bus.req0_ctrl = c0; bus.req0_a = a0; bus.req0_b = b0;
      bus.req1_valid = v1; bus.req1_ctrl = c1; bus.req1_a = a1; bus.req1_b = b1;
      bus.rsp0_ready = r0; bus.rsp1_ready = r1;
      #1;
      check("rsp0_valid", {31'b0, bus.rsp0_valid}, {31'b0, m_full0});
      check("rsp1_valid", {31'b0, bus.rsp1_valid}, {31'b0, m_full1});
      e0 = v0 && (!m_full0 || r0);
      e1 = v1 && (!m_full1 || r1);
`ifdef ALU_ARB_RR_EN
      tie_to0 = (m_last == 1'b1);
`else
      tie_to0 = 1'b1;
`endif
      g0 = e0 && (!e1 || tie_to0);
      g1 = e1 && !g0;
      check("req0_ready", {31'b0, bus.req0_ready}, {31'b0, g0});
      check("req1_ready", {31'b0, bus.req1_ready}, {31'b0, g1});
      ec = g0 ? c0 : (g1 ? c1 : 4'd0);
      ea = g0 ? a0 : (g1 ? a1 : 32'd0);
      eb = g0 ? b0 : (g1 ? b1 : 32'd0);
      check("alu_ctrl", {28'b0, bus.alu_ctrl}, {28'b0, ec});
      check("alu_a", bus.alu_a, ea);
      check("alu_b", bus.alu_b, eb);
      if (g0) begin
         exp_q0.push_back(alu_ref(c0, a0, b0));
         $display("grant port 0 ctrl=%0d a=0x%08h b=0x%08h", c0, a0, b0);
      end
      if (g1) begin
         exp_q1.push_back(alu_ref(c1, a1, b1));
         $display("grant port 1 ctrl=%0d a=0x%08h b=0x%08h", c1, a1, b1);
      end
      m_full0 = g0 ? 1'b1 : (r0 ? 1'b0 : m_full0);
      m_full1 = g1 ? 1'b1 : (r1 ? 1'b0 : m_full1);
      if (g0) m_last = 1'b0;
      else if (g1) m_last = 1'b1;
   endtask

   task automatic idle(input logic r0, input logic r1);
      cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, r0, r1);
   endtask

   // Monitor: held results must match the scoreboard head; a consumed result pops it.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (aresetn && !done) begin
            if (bus.rsp0_valid) begin
               if (exp_q0.size() == 0) begin
                  chk_cnt++;
                  $display("FAIL rsp0_unexpected: got 0x%08h expected no response", bus.rsp0_y);
               end else begin
                  check("rsp0_y", bus.rsp0_y, exp_q0[0]);
                  if (bus.rsp0_ready) begin
                     $display("rsp port 0 y=0x%08h", bus.rsp0_y);
                     void'(exp_q0.pop_front());
                  end
               end
            end
            if (bus.rsp1_valid) begin
               if (exp_q1.size() == 0) begin
                  chk_cnt++;
                  $display("FAIL rsp1_unexpected: got 0x%08h expected no response", bus.rsp1_y);
               end else begin
                  check("rsp1_y", bus.rsp1_y, exp_q1[0]);
                  if (bus.rsp1_ready) begin
                     $display("rsp port 1 y=0x%08h", bus.rsp1_y);
                     void'(exp_q1.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin
      bus.req0_valid = 1'b1; bus.req0_ctrl = OP_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
      bus.req1_valid = 1'b1; bus.req1_ctrl = OP_ADD; bus.req1_a = 32'd3; bus.req1_b = 32'd4;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

      // Reset state with requests pending.
      #3;
      check("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
      check("rst_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
      check("rst_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);
      check("rst_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
      check("rst_rsp0_y", bus.rsp0_y, 32'd0);
      check("rst_alu_a", bus.alu_a, 32'd0);
      @(posedge clk);
      #2;
      aresetn = 1'b1;

      // Single port ADD, granted in the first cycle after reset release.
      cycle(1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      idle(1'b1, 1'b1);
      check("add_rsp0_y", bus.rsp0_y, 32'd12);

      // Tie traffic every cycle.
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, OP_SUB, 32'd10, 32'd3, 1'b1, OP_XOR, 32'hF0, 32'hFF, 1'b1, 1'b1);
      end
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);

      // Backpressure on port 0 must not block port 1.
      cycle(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      cycle(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, OP_SLL, 32'd1, 32'd4, 1'b0, 1'b1);
      idle(1'b0, 1'b0);
      check("bp_rsp0_y", bus.rsp0_y, 32'd1);
      check("bp_rsp1_y", bus.rsp1_y, 32'd16);
      idle(1'b1, 1'b1);

      // Drain and accept on the same port in one cycle.
      cycle(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      cycle(1'b1, OP_OR, 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      idle(1'b0, 1'b1);
      check("drain_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
      check("drain_rsp0_y", bus.rsp0_y, 32'd3);
      idle(1'b1, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 60), 4'($urandom_range(0, 9)), $urandom, $urandom,
               ($urandom_range(0, 99) < 60), 4'($urandom_range(0, 9)), $urandom, $urandom,
               ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70));
      end

      // Reset while port 1 holds an undelivered result.
      cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, OP_ADD, 32'd8, 32'd9, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      #1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      aresetn = 1'b0;
      m_full0 = 1'b0; m_full1 = 1'b0; m_last = 1'b1;
      exp_q0.delete();
      exp_q1.delete();
      #1;
      check("mid_rst_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
      check("mid_rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
      check("mid_rst_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
      check("mid_rst_alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd0);
      @(posedge clk);
      #2;
      aresetn = 1'b1;
      cycle(1'b1, OP_SUB, 32'd10, 32'd3, 1'b1, OP_XOR, 32'hF0, 32'hFF, 1'b1, 1'b1);
      check("post_rst_tie_port0", {31'b0, bus.req0_ready}, 32'd1);

      for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
      done = 1'b1;
      check("q0_drained", exp_q0.size(), 32'd0);
      check("q1_drained", exp_q1.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/ex_alu_arbiter.md
EX_ALU_ARBITER -- requirements
Module: ex_alu_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  Clock; all state updates on the rising edge.
REQ-003 aresetn  input  1  Asynchronous active-low reset; assertion clears state immediately; deassertion is synchronous to clk.
REQ-004 reqN_valid  input  1  (N=0,1) Requester N presents an operation.
REQ-005 reqN_ready  output  1  (N=0,1) Requester N's operation is accepted this cycle.
REQ-006 reqN_ctrl  input  4  (N=0,1) ALU operation code, using the team's CTRL_ALU_* encoding.
REQ-007 reqN_a, reqN_b  input  32 each  (N=0,1) Operands.
REQ-008 rspN_valid  output  1  (N=0,1) Registered result for requester N is held.
REQ-009 rspN_ready  input  1  (N=0,1) Requester N consumes its result.
REQ-010 rspN_y  output  32  (N=0,1) Result for requester N.
REQ-011 alu_ctrl  output  4  Control to the shared combinational ALU.
REQ-012 alu_a, alu_b  output  32 each  Operands to the shared ALU.
REQ-013 alu_y  input  32  Combinational result from the shared ALU.

Function
REQ-014 Port N SHALL be eligible when reqN_valid=1 and (rspN_valid=0, or rspN_valid=1 and rspN_ready=1).
REQ-015 At most one port SHALL be granted per cycle; reqN_ready=1 only for the granted port.
REQ-016 The grant SHALL be combinational from eligibility and the priority state; reqN_ready SHALL NOT depend on reqN_valid of the other port except through arbitration.
REQ-017 If exactly one port is eligible, that port SHALL be granted.
REQ-018 If both ports are eligible, the port selected by the priority rule (REQ-031/032) SHALL be granted.
REQ-019 While port N is granted, alu_ctrl/alu_a/alu_b SHALL equal reqN_ctrl/reqN_a/reqN_b; with no grant they SHALL be driven to 0.
REQ-020 On the edge ending a grant cycle, alu_y SHALL be captured into rspN_y and rspN_valid set to 1; latency request-accept to rsp_valid is exactly 1 cycle.
REQ-021 rspN_valid SHALL clear on an edge where rspN_ready=1 and no new grant to port N occurs.
REQ-022 Simultaneous drain and grant on the same port SHALL result in rspN_valid=1 holding the new result (back-to-back throughput 1/cycle per port).
REQ-023 rspN_y SHALL remain stable while rspN_valid=1 and rspN_ready=0.
REQ-024 A full response buffer with rspN_ready=0 SHALL block port N only; the other port SHALL still be granted when eligible.
REQ-025 The priority state last_grant (1 bit) SHALL update to the granted port index on every grant cycle, and hold otherwise.
REQ-026 rspN_y contents SHALL be don't-care when rspN_valid=0; the verification bench SHALL NOT check them.

Reset
REQ-027 During aresetn=0: rsp0_valid=rsp1_valid=0, rsp0_y=rsp1_y=0, last_grant=1 (port 0 has first priority).
REQ-028 During aresetn=0, req0_ready=req1_ready=0 and alu_ctrl/alu_a/alu_b=0.
REQ-029 Reset asserted mid-operation SHALL discard buffered results with no response delivered.
REQ-030 The first grant after reset deassertion SHALL be allowed in the first cycle with aresetn=1.

Configuration
REQ-031 With macro ALU_ARB_RR_EN defined, a tie (both eligible) SHALL be granted to the port != last_grant (round-robin).
REQ-032 With ALU_ARB_RR_EN undefined, a tie SHALL always be granted to port 0 (fixed priority); last_grant SHALL still be kept but SHALL NOT affect arbitration.

Verification
REQ-033 Single port: req0 ADD a=5 b=7, rsp0_ready=1 -> req0_ready=1 the same cycle; rsp0_valid=1, rsp0_y=12 the next cycle.
REQ-034 Tie, RR on: both valid every cycle (req0 SUB 10,3; req1 XOR 0xF0,0xFF), rsp ready=1 -> grants 0,1,0,1...; rsp0_y=7, rsp1_y=0x0F.
REQ-035 Tie, RR off: same stimulus -> port 0 granted every cycle; req1_ready stays 0.
REQ-036 Backpressure: rsp0_ready=0 after one result (SLT 0xFFFFFFFF,1 -> 1) -> req0_ready=0, rsp0_y holds 1; req1 SLL 1,4 -> granted, rsp1_y=16.
REQ-037 Same-cycle drain and accept: rsp0_valid=1, rsp0_ready=1, req0 OR 0x1,0x2 -> rsp0_valid stays 1, rsp0_y=3 the next cycle.
REQ-038 Reset mid-flight: aresetn=0 while rsp1_valid=1 -> rsp1_valid=0 immediately; after release, first tied request goes to port 0.
